neuron_activation_stage: RTL and testbench

//  Downstream of the per-neuron accumulator: takes one accumulated dot-product sum per neuron,

---
 rtl/neuron_activation_stage.sv | 194 +++++++++++++++++++
 tb/tb_neuron_activation_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_activation_stage.sv
// neuron_activation_stage: per-neuron bias add, ReLU (or leaky ReLU when
// ACT_LEAKY_RELU_EN is defined), fixed-point rescale and saturation,
// packing results into a layer output vector.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   sum_valid/sum_ready    input handshake for sum_in, bias_in, num_neurons
//   sum_in, bias_in        signed accumulated sum and bias (ACC_W)
//   num_neurons            layer size, sampled on the first sum of a vector
//   vec_valid/vec_ready    output vector handshake
//   vec_out                slot i at [i*OUT_W +: OUT_W]
//   vec_count              slots written in the presented vector
//   sat_flag               some slot of this vector saturated
module neuron_activation_stage #(
    parameter int MAX_NEURONS = 8,
    parameter int ACC_W       = 32,
    parameter int OUT_W       = 16,
    parameter int FRAC_SHIFT  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sum_valid,
    output logic                           sum_ready,
    input  logic [ACC_W-1:0]               sum_in,
    input  logic [ACC_W-1:0]               bias_in,
    input  logic [$clog2(MAX_NEURONS+1)-1:0] num_neurons,
    output logic                           vec_valid,
    input  logic                           vec_ready,
    output logic [MAX_NEURONS*OUT_W-1:0]   vec_out,
    output logic [$clog2(MAX_NEURONS+1)-1:0] vec_count,
    output logic                           sat_flag
);

    localparam int CW = $clog2(MAX_NEURONS+1);
    localparam int SW = ACC_W + 1;
    localparam logic [CW-1:0] NMAX = CW'(MAX_NEURONS);
    localparam logic signed [SW-1:0] OMAX = SW'(2**(OUT_W-1) - 1);
    localparam logic signed [SW-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] count;
    logic [CW-1:0] n_eff;
    logic [CW-1:0] n_in;
    logic [CW-1:0] n_cur;

    logic                 s1_vld;
    logic                 s1_last;
    logic [CW-1:0]        s1_idx;
    logic signed [SW-1:0] s1;
    logic                 wr_last;

    logic signed [SW-1:0] act;
    logic signed [SW-1:0] shr;
    logic [OUT_W-1:0]     res;
    logic                 res_sat;

    logic [OUT_W-1:0] slot [MAX_NEURONS];
    logic             sat;

    logic accept;
    logic last_acc;
    logic vhs;

    assign accept = sum_valid && sum_ready;
    assign vhs    = vec_valid && vec_ready;

    // Zero or oversize layer requests fall back to the full vector.
    always_comb begin
        n_in = num_neurons;
        if (num_neurons == '0 || num_neurons > NMAX)
            n_in = NMAX;
    end

    // The first sum of a vector uses the live request, later ones the latch.
    assign n_cur    = (count == '0) ? n_in : n_eff;
    assign last_acc = accept && ((count + CW'(1)) == n_cur);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (last_acc)  state_nxt = DRAIN;
            DRAIN:   if (wr_last)   state_nxt = PRESENT;
            PRESENT: if (vec_ready) state_nxt = COLLECT;
            default:                state_nxt = COLLECT;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        sum_ready = 1'b0;
        vec_valid = 1'b0;
        unique case (state)
            COLLECT: sum_ready = (count < n_eff);
            PRESENT: vec_valid = 1'b1;
            default: ;
        endcase
    end

    // Count and layer size. n_eff idles at the maximum so that
    // the first sum of a vector is always admissible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            n_eff <= NMAX;
        end else if (vhs) begin
            count <= '0;
            n_eff <= NMAX;
        end else if (accept) begin
            count <= count + CW'(1);
            if (count == '0)
                n_eff <= n_in;
        end
    end

    // Stage 1: widened bias add, cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_idx  <= '0;
            s1      <= '0;
            wr_last <= 1'b0;
        end else begin
            s1_vld  <= accept;
            s1_last <= last_acc;
            wr_last <= s1_vld && s1_last;
            if (accept) begin
                s1_idx <= count;
                s1     <= {sum_in[ACC_W-1], sum_in}
                        + {bias_in[ACC_W-1], bias_in};
            end
        end
    end

    // Stage 2: activation, rescale, saturate.
    always_comb begin
`ifdef ACT_LEAKY_RELU_EN
        act = (s1 < 0) ? (s1 >>> 3) : s1;
`else
        act = (s1 < 0) ? '0 : s1;
`endif
        shr     = act >>> FRAC_SHIFT;
        res     = shr[OUT_W-1:0];
        res_sat = 1'b0;
        if (shr > OMAX) begin
            res     = OMAX[OUT_W-1:0];
            res_sat = 1'b1;
        end else if (shr < OMIN) begin
            res     = OMIN[OUT_W-1:0];
            res_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_NEURONS; i++)
                slot[i] <= '0;
            sat <= 1'b0;
        end else if (vhs) begin
            for (int i = 0; i < MAX_NEURONS; i++)
                slot[i] <= '0;
            sat <= 1'b0;
        end else if (s1_vld) begin
            for (int i = 0; i < MAX_NEURONS; i++)
                if (s1_idx == CW'(i))
                    slot[i] <= res;
            if (res_sat)
                sat <= 1'b1;
        end
    end

    for (genvar g = 0; g < MAX_NEURONS; g++) begin : g_pack
        assign vec_out[g*OUT_W +: OUT_W] = slot[g];
    end

    assign vec_count = count;
    assign sat_flag  = sat;

endmodule

// File: tb/tb_neuron_activation_stage.sv
// tb_neuron_activation_stage: random and directed vectors, scoreboard
// queue filled by the driver and drained by a negedge monitor.
module tb_neuron_activation_stage;

    localparam int MAXN = 8;
    localparam int AW   = 32;
    localparam int OW   = 16;
    localparam int CW   = $clog2(MAXN+1);
    localparam int VW   = MAXN*OW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sum_valid;
    logic          sum_ready;
    logic [AW-1:0] sum_in;
    logic [AW-1:0] bias_in;
    logic [CW-1:0] num_neurons;
    logic          vec_valid;
    logic          vec_ready;
    logic [VW-1:0] vec_out;
    logic [CW-1:0] vec_count;
    logic          sat_flag;

    always #5 clk = ~clk;

    neuron_activation_stage #(
        .MAX_NEURONS(MAXN),
        .ACC_W(AW),
        .OUT_W(OW),
        .FRAC_SHIFT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sum_valid(sum_valid),
        .sum_ready(sum_ready),
        .sum_in(sum_in),
        .bias_in(bias_in),
        .num_neurons(num_neurons),
        .vec_valid(vec_valid),
        .vec_ready(vec_ready),
        .vec_out(vec_out),
        .vec_count(vec_count),
        .sat_flag(sat_flag)
    );

    typedef struct {
        logic [VW-1:0] vec;
        int            cnt;
        bit            sat;
        int            acc;
    } exp_t;

    exp_t   sbq[$];
    longint pend_s[$];
    int     pend_n;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     ncyc  = 0;
    bit     force_low = 1'b0;

    task automatic chk(input string nm, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference: floor divisions done explicitly on 64-bit integers.
    function automatic longint ref_act(input longint s, output bit sat);
        longint a, r;
        if (s >= 0) a = s;
`ifdef ACT_LEAKY_RELU_EN
        else a = (s - 7) / 8;
`else
        else a = 0;
`endif
        r = (a >= 0) ? a / 256 : (a - 255) / 256;
        sat = 1'b0;
        if (r > 32767) begin r = 32767; sat = 1'b1; end
        if (r < -32768) begin r = -32768; sat = 1'b1; end
        return r;
    endfunction

    task automatic send(input int sum, input int bias, input int nn);
        bit     r;
        int     g;
        bit     sa;
        longint v;
        exp_t   e;
        sum_valid   = 1'b1;
        sum_in      = sum;
        bias_in     = bias;
        num_neurons = CW'(nn);
        g = 0;
        do begin
            @(negedge clk);
            r = sum_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!r && g < 300);
        sum_valid = 1'b0;
        if (!r) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no sum_ready expected sum_ready=1");
            return;
        end
        if (pend_s.size() == 0)
            pend_n = (nn == 0 || nn > MAXN) ? MAXN : nn;
        pend_s.push_back(longint'(sum) + longint'(bias));
        if (pend_s.size() == pend_n) begin
            e.vec = '0;
            e.sat = 1'b0;
            for (int i = 0; i < pend_n; i++) begin
                v = ref_act(pend_s[i], sa);
                e.vec[i*OW +: OW] = v[OW-1:0];
                e.sat = e.sat | sa;
            end
            e.cnt = pend_n;
            e.acc = ncyc;
            sbq.push_back(e);
            pend_s.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((sbq.size() != 0 || vec_valid) && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        n_cmp++;
        if (g >= 400) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     sbq.size());
        end
        idle(2);
    endtask

    task automatic reset_checks();
        @(negedge clk);
        chk("rst_sum_ready", VW'(sum_ready), VW'(1));
        chk("rst_vec_valid", VW'(vec_valid), VW'(0));
        chk("rst_vec_out", vec_out, '0);
        chk("rst_vec_count", VW'(vec_count), VW'(0));
        chk("rst_sat_flag", VW'(sat_flag), VW'(0));
    endtask

    function automatic int rnd_val();
        unique case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 10000)) - 5000;
            1: return int'($urandom_range(0, 1 << 24)) - (1 << 23);
            2: return int'($urandom);
            default: return int'($urandom_range(0, 1 << 20)) + 32'h7FF0_0000;
        endcase
    endfunction

    // Consumer readiness
    initial begin
        vec_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            vec_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor
    bit            in_present = 1'b0;
    bit            post_hs    = 1'b0;
    logic [VW-1:0] cap_vec;
    logic [CW-1:0] cap_cnt;
    logic          cap_sat;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            in_present = 1'b0;
            post_hs    = 1'b0;
        end else begin
            if (post_hs) begin
                chk("hs_clear_vec", vec_out, '0);
                chk("hs_clear_cnt", VW'(vec_count), VW'(0));
                chk("hs_clear_sat", VW'(sat_flag), VW'(0));
                chk("hs_sum_ready", VW'(sum_ready), VW'(1));
                post_hs = 1'b0;
            end
            if (vec_valid) begin
                chk("present_sum_ready", VW'(sum_ready), VW'(0));
                if (!in_present) begin
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_vec: got %h expected none",
                                 vec_out);
                    end else begin
                        e = sbq.pop_front();
                        chk("vec_out", vec_out, e.vec);
                        chk("vec_count", VW'(vec_count), VW'(e.cnt));
                        chk("sat_flag", VW'(sat_flag), VW'(e.sat));
                        chk("latency", VW'(ncyc), VW'(e.acc + 2));
                    end
                    cap_vec    = vec_out;
                    cap_cnt    = vec_count;
                    cap_sat    = sat_flag;
                    in_present = 1'b1;
                end else begin
                    chk("hold_vec", vec_out, cap_vec);
                    chk("hold_cnt", VW'(vec_count), VW'(cap_cnt));
                    chk("hold_sat", VW'(sat_flag), VW'(cap_sat));
                end
                if (vec_ready) begin
                    in_present = 1'b0;
                    post_hs    = 1'b1;
                end
            end else if (in_present) begin
                n_cmp++;
                n_bad++;
                $display("FAIL valid_dropped: got vec_valid=0 expected 1");
                in_present = 1'b0;
            end
        end
        ncyc++;
    end

    initial begin
        int nn;
        int len;
        rst_n       = 1'b0;
        sum_valid   = 1'b0;
        sum_in      = '0;
        bias_in     = '0;
        num_neurons = '0;
        idle(3);
        rst_n = 1'b1;
        reset_checks();
        idle(1);

        send(1000, 24, 3);
        send(512, 0, 3);
        send(-500, 0, 3);
        wait_drain();

        send(32'h4000_0000, 0, 1);
        wait_drain();
        send(256, 0, 1);
        wait_drain();

        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1);
        wait_drain();

        force_low = 1'b1;
        send(70000, -300, 2);
        send(-90000, 5, 2);
        fork
            send(123456, 7, 1);
            begin
                idle(8);
                force_low = 1'b0;
            end
        join
        wait_drain();

        for (int i = 0; i < MAXN; i++) begin
            send(int'($urandom_range(0, 1 << 20)), i * 100, 0);
            idle(1);
        end
        wait_drain();

        for (int v = 0; v < 30; v++) begin
            nn  = int'($urandom_range(0, 15));
            len = (nn == 0 || nn > MAXN) ? MAXN : nn;
            for (int k = 0; k < len; k++) begin
                send(rnd_val(), rnd_val(),
                     (k == 0) ? nn : int'($urandom_range(0, 15)));
                idle(int'($urandom_range(0, 2)));
            end
        end
        wait_drain();

        send(40000, 0, 5);
        send(50000, 0, 5);
        rst_n = 1'b0;
        pend_s.delete();
        idle(3);
        rst_n = 1'b1;
        reset_checks();
        idle(1);
        send(-7000, 2000, 2);
        send(9000, -1, 2);
        wait_drain();

        chk("queue_empty", VW'(sbq.size()), VW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
